// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (1 start, 8 data LSB-first, 1 stop, no parity).
// The rx line is synchronised by two flops; every decision uses rx_s only.
// Bit centres are located by counting HALF cycles into the start bit and then
// DIV cycles per bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   data[7:0]  last correctly received byte (held until the next good frame)
//   valid      one-cycle pulse, data is new this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = F / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state_q, state_d;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      sr_q;
  logic            cnt_half, cnt_last, smp;
  logic            valid_d, ferr_d;

  // 2-flop synchroniser, idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign cnt_half = (cnt_q == CW'(HALF - 1));
  assign cnt_last = (cnt_q == CW'(DIV - 1));

  // Sample point: centre of the start bit, then the centre of every later bit
  always_comb begin
    smp = 1'b0;
    case (state_q)
      START:     smp = cnt_half;
      DATA, STOP: smp = cnt_last;
      default:   smp = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      // a start bit that is high again at its centre was a glitch
      START: if (smp) state_d = rx_s ? IDLE : DATA;
      DATA:  if (smp && bit_q == 3'd7) state_d = STOP;
      STOP:  if (smp) state_d = rx_s ? IDLE : BRK;
      // stay here until the line returns high so a held-low line
      // cannot start new frames or raise repeated frame errors
      BRK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state_q != IDLE);
    valid_d = (state_q == STOP) && smp && rx_s;
    ferr_d  = (state_q == STOP) && smp && !rx_s;
  end

  // Cycle counter: restarts on every state entry and at every sample point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q || smp) begin
      cnt_q <= '0;
    end else if (state_q == START || state_q == DATA || state_q == STOP) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  // Bit index and shift register; LSB arrives first so shift right from MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q <= '0;
      sr_q  <= '0;
    end else begin
      if (state_q == START && state_d == DATA) bit_q <= '0;
      else if (state_q == DATA && smp)         bit_q <= bit_q + 3'd1;
      if (state_q == DATA && smp) sr_q <= {rx_s, sr_q[7:1]};
    end
  end

  // Registered outputs; data only updates on a good stop bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= valid_d;
      frame_err <= ferr_d;
      if (valid_d) data <= sr_q;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. A default-rate instance covers timing, glitch,
// framing error, break and reset; a second, slow-clock instance receives a
// counter stream the way a uart_tx loopback would deliver it.
module tb_uart_rx;

  localparam int BAUD    = 115200;
  localparam int F       = 50000000;
  localparam int DIV     = F / BAUD;
  localparam int HALF    = DIV / 2;
  localparam int LAT     = HALF + 9 * DIV + 3;
  localparam int BAUD_LB = 6250;
  localparam int F_LB    = 50000;
  localparam int DIV_LB  = F_LB / BAUD_LB;

  if (DIV < 4 || DIV_LB < 4) begin : g_div_chk
    initial begin
      $display("FAIL div_min DIV=%0d DIV_LB=%0d need>=4", DIV, DIV_LB);
      $fatal(1, "bit period too short");
    end
  end

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1, rx_lb = 1'b1;
  logic [7:0] data, data_lb;
  logic       valid, frame_err, busy;
  logic       valid_lb, frame_err_lb, busy_lb;

  uart_rx #(.BAUD(BAUD), .F(F)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .busy(busy));

  uart_rx #(.BAUD(BAUD_LB), .F(F_LB)) dut_lb (
    .clk(clk), .rst(rst), .rx(rx_lb), .data(data_lb), .valid(valid_lb),
    .frame_err(frame_err_lb), .busy(busy_lb));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$], exp_lb_q[$];
  int nvalid = 0, nferr = 0, nvalid_lb = 0, nferr_lb = 0;
  int last_vc = 0, prev_vc = 0;
  logic valid_q = 1'b0, valid_lb_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  // Scoreboard monitors: every valid pops the oldest expected byte
  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      prev_vc = last_vc;
      last_vc = cyc;
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rx_data", 32'(data), 32'(exp_q.pop_front()));
      chk("valid_1cyc", 32'(valid_q), 32'd0);
    end
    if (frame_err) nferr++;
    if (valid || frame_err) chk("valid_ferr_excl", 32'(valid & frame_err), 32'd0);
    valid_q = valid;
  end

  always @(negedge clk) begin
    if (valid_lb) begin
      nvalid_lb++;
      chk("lb_sb_pending", 32'(exp_lb_q.size() > 0), 32'd1);
      if (exp_lb_q.size() > 0) chk("lb_data", 32'(data_lb), 32'(exp_lb_q.pop_front()));
      chk("lb_valid_1cyc", 32'(valid_lb_q), 32'd0);
    end
    if (frame_err_lb) nferr_lb++;
    valid_lb_q = valid_lb;
  end

  // Drive the first nbits of a frame {stop, data, start}, LSB first.
  // Caller is aligned to a falling clock edge.
  task automatic send(input bit lb, input logic [7:0] b, input logic stopb, input int nbits);
    logic [9:0] f;
    int div;
    f   = {stopb, b, 1'b0};
    div = lb ? DIV_LB : DIV;
    for (int i = 0; i < nbits; i++) begin
      if (lb) rx_lb = f[i];
      else    rx    = f[i];
      repeat (div) @(negedge clk);
    end
  endtask

  initial begin
    int t0, n0, nf0;

    // reset state
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lb_busy", 32'(busy_lb), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // single frame: data, latency from start edge, no frame error
    n0 = nvalid; t0 = cyc;
    exp_q.push_back(8'hA5);
    send(0, 8'hA5, 1'b1, 10);
    chk("t1_nvalid", 32'(nvalid - n0), 32'd1);
    chk_rng("t1_latency", last_vc - t0, LAT - 1, LAT + 1);
    chk("t1_nferr", 32'(nferr), 32'd0);
    chk("t1_hold", 32'(data), 32'hA5);

    // back-to-back frames, no idle gap
    n0 = nvalid;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(0, 8'h00, 1'b1, 10);
    send(0, 8'hFF, 1'b1, 10);
    chk("t2_nvalid", 32'(nvalid - n0), 32'd2);
    chk_rng("t2_spacing", last_vc - prev_vc, 10 * DIV - 1, 10 * DIV + 1);
    chk("t2_data", 32'(data), 32'hFF);
    repeat (DIV) @(negedge clk);

    // short low glitch: rejected at start-bit centre
    n0 = nvalid; nf0 = nferr;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    chk("t3_busy_hi", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (HALF + 10) @(negedge clk);
    chk("t3_busy_lo", 32'(busy), 32'd0);
    chk("t3_nvalid", 32'(nvalid - n0), 32'd0);
    chk("t3_nferr", 32'(nferr - nf0), 32'd0);

    // bad stop bit, then line held low (break), then a good frame
    n0 = nvalid; nf0 = nferr;
    send(0, 8'h3C, 1'b0, 10);
    rx = 1'b0;
    repeat (20000) @(negedge clk);
    chk("t4_nferr", 32'(nferr - nf0), 32'd1);
    chk("t4_nvalid", 32'(nvalid - n0), 32'd0);
    chk("t4_data_held", 32'(data), 32'hFF);
    chk("t4_busy_brk", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    chk("t4_busy_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h12);
    send(0, 8'h12, 1'b1, 10);
    chk("t4_nvalid2", 32'(nvalid - n0), 32'd1);
    chk("t4_data2", 32'(data), 32'h12);
    chk("t4_nferr2", 32'(nferr - nf0), 32'd1);

    // reset mid-frame, then a clean frame after an idle gap
    repeat (DIV) @(negedge clk);
    send(0, 8'h55, 1'b1, 5);
    rst = 1'b0;
    #1;
    chk("t5_data", 32'(data), 32'h00);
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_ferr", 32'(frame_err), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (11 * DIV) @(negedge clk);
    n0 = nvalid;
    exp_q.push_back(8'h81);
    send(0, 8'h81, 1'b1, 10);
    chk("t5_nvalid", 32'(nvalid - n0), 32'd1);
    chk("t5_data2", 32'(data), 32'h81);

    // counter stream as a transmitter loopback would send it: 0..7 then 0
    n0 = nvalid_lb;
    for (int i = 0; i < 9; i++) begin
      exp_lb_q.push_back(8'(i % 8));
      send(1, 8'(i % 8), 1'b1, 10);
    end
    repeat (2 * DIV_LB) @(negedge clk);
    chk("t6_nvalid", 32'(nvalid_lb - n0), 32'd9);
    chk("t6_nferr", 32'(nferr_lb), 32'd0);
    chk("t6_last", 32'(data_lb), 32'h00);

    // nothing left unmatched in either scoreboard
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("sb_lb_empty", 32'(exp_lb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
